// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state-code and ALU constants for the multicycle MIPS control FSM.
package cpu_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_LI  = 6'b111001;
  localparam logic [5:0] OP_LUI = 6'b111010;
  localparam logic [5:0] OP_LWI = 6'b111011;
  localparam logic [5:0] OP_SWI = 6'b111100;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_RTYPE  = 4'd2;
  localparam state_t S_WB     = 4'd3;
  localparam state_t S_ITYPE  = 4'd4;
  localparam state_t S_BEQC   = 4'd5;
  localparam state_t S_BNEC   = 4'd6;
  localparam state_t S_JUMPC  = 4'd7;
  localparam state_t S_LOAD   = 4'd8;
  localparam state_t S_MEMWB  = 4'd9;
  localparam state_t S_STORE  = 4'd10;
  localparam state_t S_STWR   = 4'd11;
  localparam state_t S_FAULT  = 4'd12;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  // States whose exit to FETCH completes an instruction; DECODE only exits to FETCH on NOP.
  function automatic logic retires_into_fetch(state_t s);
    case (s)
      S_WB, S_MEMWB, S_BEQC, S_BNEC, S_JUMPC, S_STWR, S_DECODE: retires_into_fetch = 1'b1;
      default:                                                 retires_into_fetch = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_timeout.sv
// Bounded-wait counter for memory handshakes; expired flags the last allowed wait cycle.
module cpu_ctrl_timeout #(
  parameter int MEM_TIMEOUT = 8,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default first so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_limit
      assign expired = 1'b0;
    end else begin : g_limit
      assign expired = en && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/cpu_control_hs.sv
// Multicycle MIPS control FSM with request/ack memory handshakes and timeout fault.
// Optional retired-instruction counter enabled by defining CPU_CONTROL_RETIRE_CNT_EN.
module cpu_control_hs
  import cpu_ctrl_pkg::*;
#(
  parameter int ALUSIZE     = 4,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic               IMemAck,
  input  logic               DMemAck,
  output logic [3:0]         SystemState,
  output logic               PCSource,
  output logic               PCWrite,
  output logic               BEQcontrol,
  output logic               BNEcontrol,
  output logic [ALUSIZE-1:0] AluOp,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic               IRWrite,
  output logic               RFWrite,
  output logic               MDRWrite,
  output logic               DMemWrite,
  output logic               MemToReg,
  output logic               ImmedAddr,
  output logic               ReadDataSrc1,
  output logic               ReadDataSrc2,
  output logic               IMemReq,
  output logic               DMemReq,
  output logic               Fault
`ifdef CPU_CONTROL_RETIRE_CNT_EN
  ,
  output logic [31:0]        RetireCount
`endif
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t state_q, state_d;
  logic   to_en, to_clr, to_expired;

  always_comb begin
    case (state_q)
      S_FETCH:        to_en = !IMemAck;
      S_LOAD, S_STWR: to_en = !DMemAck;
      default:        to_en = 1'b0;
    endcase
  end

  assign to_clr = (state_d != state_q);

  cpu_ctrl_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk     (Clk),
    .reset   (Reset),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (IMemAck)         state_d = S_DECODE;
        else if (to_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (Opcode == OP_NOP)         state_d = S_FETCH;
        else if (Opcode == OP_BEQ)    state_d = S_BEQC;
        else if (Opcode == OP_BNE)    state_d = S_BNEC;
        else if (Opcode == OP_J)      state_d = S_JUMPC;
        else if (Opcode == OP_LWI)    state_d = S_LOAD;
        else if (Opcode == OP_SWI)    state_d = S_STORE;
        else if (Opcode[5:4] == 2'b11) state_d = S_ITYPE;
        else                          state_d = S_RTYPE;
      end
      S_RTYPE, S_ITYPE:                 state_d = S_WB;
      S_WB, S_BEQC, S_BNEC, S_JUMPC,
      S_MEMWB:                          state_d = S_FETCH;
      S_LOAD: begin
        if (DMemAck)         state_d = S_MEMWB;
        else if (to_expired) state_d = S_FAULT;
      end
      S_STORE:                          state_d = S_STWR;
      S_STWR: begin
        if (DMemAck)         state_d = S_FETCH;
        else if (to_expired) state_d = S_FAULT;
      end
      S_FAULT:                          state_d = S_FAULT;
      default:                          state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign SystemState = state_q;

  always_comb begin
    PCSource     = 1'b0;
    PCWrite      = 1'b0;
    BEQcontrol   = 1'b0;
    BNEcontrol   = 1'b0;
    AluOp        = '0;
    AluSrcA      = 1'b0;
    AluSrcB      = 2'd0;
    IRWrite      = 1'b0;
    RFWrite      = 1'b0;
    MDRWrite     = 1'b0;
    DMemWrite    = 1'b0;
    MemToReg     = 1'b0;
    ImmedAddr    = 1'b0;
    ReadDataSrc1 = 1'b1;
    ReadDataSrc2 = 1'b1;
    IMemReq      = 1'b0;
    DMemReq      = 1'b0;
    Fault        = 1'b0;
    case (state_q)
      S_FETCH: begin
        IMemReq = 1'b1;
        AluOp   = ALUSIZE'(ALU_ADD);
        PCWrite = IMemAck;
        IRWrite = IMemAck;
      end
      S_DECODE: begin
        AluOp   = ALUSIZE'(ALU_ADD);
        AluSrcB = 2'd3;
        if (Opcode == OP_BEQ || Opcode == OP_BNE) begin
          ReadDataSrc1 = 1'b0;
          ReadDataSrc2 = 1'b0;
        end
        if (Opcode == OP_J) AluSrcB = 2'd2;
        if (Opcode == OP_LI || Opcode == OP_LUI) ReadDataSrc1 = 1'b0;
      end
      S_RTYPE, S_ITYPE: begin
        AluOp   = Opcode[ALUSIZE-1:0];
        AluSrcA = 1'b1;
        AluSrcB = (state_q == S_ITYPE) ? 2'd3 : 2'd1;
      end
      S_WB: begin
        RFWrite = 1'b1;
        AluSrcA = 1'b1;
        AluSrcB = 2'd1;
      end
      S_BEQC, S_BNEC: begin
        PCSource   = 1'b1;
        AluOp      = ALUSIZE'(ALU_SUB);
        AluSrcA    = 1'b1;
        AluSrcB    = 2'd1;
        BEQcontrol = (state_q == S_BEQC);
        BNEcontrol = (state_q == S_BNEC);
      end
      S_JUMPC: begin
        PCSource = 1'b1;
        PCWrite  = 1'b1;
      end
      S_LOAD: begin
        DMemReq  = 1'b1;
        MDRWrite = DMemAck;
      end
      S_MEMWB: begin
        RFWrite  = 1'b1;
        MemToReg = 1'b1;
      end
      S_STORE: ReadDataSrc1 = 1'b0;
      S_STWR: begin
        DMemReq      = 1'b1;
        DMemWrite    = 1'b1;
        ReadDataSrc1 = 1'b0;
      end
      S_FAULT: Fault = 1'b1;
      default: ;
    endcase
    // Reset must silence every write enable and request immediately, before the edge lands.
    if (Reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RFWrite   = 1'b0;
      MDRWrite  = 1'b0;
      DMemWrite = 1'b0;
      IMemReq   = 1'b0;
      DMemReq   = 1'b0;
    end
  end

`ifdef CPU_CONTROL_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (state_d == S_FETCH && retires_into_fetch(state_q)) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign RetireCount = retire_q;
`endif

endmodule
